dip_rgb565_ycrcb: RTL and testbench
===================================

// Module: dip_rgb565_ycrcb
// PURPOSE
//  Pixel-rate colour-space converter in the camera DIP chain: takes RGB565 pixels
//  from the OV5640 capture path and converts them to BT.601 full-range YCbCr.
//  Emits a 16-bit word for the SDRAM write FIFO. The default output is the
//  grayscale pixel (Y) repacked as RGB565 for the Sobel/erode/dilate stages.
//  Fixed 3-cycle pipeline; the valid strobe travels alongside the data.
// PARAMETERS
//  OUT_SEL  0  output format: 0 = Y gray as RGB565 {Y[7:3],Y[7:2],Y[7:3]};
//              1 = {Y[7:0],Cb[7:0]}; 2 = {Y[7:0],Cr[7:0]}; other values behave as 0
// PORTS
//  pclk           in   1   pixel clock; all logic on its rising edge
//  rst_n          in   1   asynchronous active-low reset
//  dip_en         in   1   input pixel valid, one pixel per high cycle
//  dip_data       in   16  RGB565 pixel {R[15:11],G[10:5],B[4:0]}
//  sdram_wr_data  out  16  converted pixel (format per OUT_SEL)
//  sdram_wr_en    out  1   output valid, dip_en delayed exactly 3 cycles
// BEHAVIOUR
//  - Interface: one clock (pclk); reset is asynchronous, active-low (rst_n).
//  - Reset: all pipeline registers, sdram_wr_data = 16'h0000, sdram_wr_en = 0.
//    A mid-stream reset discards all in-flight pixels; no en pulse after release.
//  - Stage 1, capture when dip_en = 1: expand to 8 bits by MSB replication:
//    R8={R5,R5[4:2]}, G8={G6,G6[5:4]}, B8={B5,B5[4:2]}. Register the nine
//    unsigned products 77R,150G,29B / 43R,85G,128B / 128R,107G,21B (16 bit each).
//  - Stage 2: register the unsigned 16-bit sums:
//    Ys = 77R+150G+29B;  Cbs = 32768+128B-43R-85G;  Crs = 32768+128R-107G-21B.
//    Bound: 43+85 = 107+21 = 128, so the Cb/Cr sums stay in 128..65408.
//    No overflow, no negative values, no clamping needed.
//  - Stage 3: Y=Ys[15:8], Cb=Cbs[15:8], Cr=Crs[15:8] (truncate, no rounding).
//    Pack per OUT_SEL into sdram_wr_data.
//  - Valid pipe: v1<=dip_en, v2<=v1, sdram_wr_en<=v2; it is free-running.
//    A data stage register loads only when its incoming valid is 1; otherwise it
//    holds. sdram_wr_data therefore holds the last pixel between valid beats.
//  - Sustains back-to-back valids (1 pixel/clk) and any gap pattern.
//    Output order equals input order; no back-pressure exists.
// STRUCTURE
//  - Shared package dip_pkg holds the coefficient localparams: KYR=77, KYG=150,
//    KYB=29, KCBR=43, KCBG=85, KCRG=107, KCRB=21, K128=128, OFS=32768.
//    It also holds the OUT_SEL encodings.
//  - One natural sub-module, dip_rgb565_expand: combinational 565 -> 888 expansion.
//    Everything else is flat in this module.
// TESTING
//  - Reset held 200 ns, then released: sdram_wr_en = 0 and sdram_wr_data = 0
//    throughout reset and for the first 3 cycles after release.
//  - Single pulse dip_en=1, dip_data=16'hFFFF: exactly 3 cycles later one en
//    pulse. Y=255, Cb=Cr=128, gray out 16'hFFFF.
//  - 16'hF800 (red): Y=76 -> out 16'h4A69; OUT_SEL=1 -> 16'h4C55 (Cb=85);
//    OUT_SEL=2 -> 16'h4CFF (Cr=255).
//  - 16'h0000 -> out 16'h0000 (Cb=Cr=128); 16'h07E0 (green) -> Y=149;
//    16'h001F (blue) -> Y=28.
//  - dip_en toggling every cycle, dip_data incrementing on each valid:
//    sdram_wr_en equals dip_en delayed by 3 cycles.
//    Each output matches a golden model of the input sequence; data holds on
//    idle cycles.
//  - Continuous valid stream with rst_n pulsed low mid-stream: outputs clear
//    immediately. First en after release arrives 3 cycles after the first new
//    dip_en.

Source files
------------

// File: rtl/dip_pkg.sv
// Shared constants for the DIP colour-space converter: BT.601 full-range
// coefficients, output-format encodings and the stage-1 product bundle.
package dip_pkg;

  localparam logic [7:0]  KYR  = 8'd77;
  localparam logic [7:0]  KYG  = 8'd150;
  localparam logic [7:0]  KYB  = 8'd29;
  localparam logic [7:0]  KCBR = 8'd43;
  localparam logic [7:0]  KCBG = 8'd85;
  localparam logic [7:0]  KCRG = 8'd107;
  localparam logic [7:0]  KCRB = 8'd21;
  localparam logic [7:0]  K128 = 8'd128;
  localparam logic [15:0] OFS  = 16'd32768;

  localparam int SEL_GRAY = 0;
  localparam int SEL_Y_CB = 1;
  localparam int SEL_Y_CR = 2;

  typedef struct packed {
    logic [15:0] yr;
    logic [15:0] yg;
    logic [15:0] yb;
    logic [15:0] cbr;
    logic [15:0] cbg;
    logic [15:0] cbb;
    logic [15:0] crr;
    logic [15:0] crg;
    logic [15:0] crb;
  } prod_t;

  // 8x8 unsigned multiply kept at 16 bits; every coefficient*255 fits.
  function automatic logic [15:0] mul8(input logic [7:0] k, input logic [7:0] x);
    return {8'd0, k} * {8'd0, x};
  endfunction

endpackage

// File: rtl/dip_rgb565_ycrcb_if.sv
// Pixel stream into the converter and SDRAM-FIFO write stream out of it.
interface dip_rgb565_ycrcb_if;
  logic        dip_en;
  logic [15:0] dip_data;
  logic        sdram_wr_en;
  logic [15:0] sdram_wr_data;

  modport master (output dip_en, dip_data, input sdram_wr_en, sdram_wr_data);
  modport slave  (input dip_en, dip_data, output sdram_wr_en, sdram_wr_data);
endinterface

// File: rtl/dip_rgb565_expand.sv
// Combinational RGB565 -> RGB888 expansion by MSB replication, so full-scale
// 5/6-bit codes map to exactly 255.
module dip_rgb565_expand (
  input  logic [15:0] pix,
  output logic [7:0]  r8,
  output logic [7:0]  g8,
  output logic [7:0]  b8
);
  assign r8 = {pix[15:11], pix[15:13]};
  assign g8 = {pix[10:5],  pix[10:9]};
  assign b8 = {pix[4:0],   pix[4:2]};
endmodule

// File: rtl/dip_rgb565_ycrcb.sv
// RGB565 -> BT.601 full-range YCbCr, fixed 3-stage pipeline with a free-running
// valid pipe; data stages load only on their incoming valid and hold otherwise.
module dip_rgb565_ycrcb
  import dip_pkg::*;
#(
  parameter int OUT_SEL = 0
) (
  input  logic        pclk,
  input  logic        rst_n,
  input  logic        dip_en,
  input  logic [15:0] dip_data,
  output logic [15:0] sdram_wr_data,
  output logic        sdram_wr_en
);

  logic [7:0]  r8, g8, b8;
  logic        v1_q, v1_d, v2_q, v2_d, en_q, en_d;
  prod_t       prod_q, prod_d;
  logic [15:0] ys_q, ys_d, cbs_q, cbs_d, crs_q, crs_d;
  logic [15:0] out_q, out_d;

  dip_rgb565_expand u_expand (
    .pix (dip_data),
    .r8  (r8),
    .g8  (g8),
    .b8  (b8)
  );

  function automatic logic [15:0] pack_out(input logic [7:0] y, input logic [7:0] cb,
                                           input logic [7:0] cr);
    case (OUT_SEL)
      SEL_Y_CB: return {y, cb};
      SEL_Y_CR: return {y, cr};
      default:  return {y[7:3], y[7:2], y[7:3]};
    endcase
  endfunction

  always_comb begin
    v1_d   = dip_en;
    v2_d   = v1_q;
    en_d   = v2_q;
    prod_d = prod_q;
    ys_d   = ys_q;
    cbs_d  = cbs_q;
    crs_d  = crs_q;
    out_d  = out_q;

    if (dip_en) begin
      prod_d.yr  = mul8(KYR,  r8);
      prod_d.yg  = mul8(KYG,  g8);
      prod_d.yb  = mul8(KYB,  b8);
      prod_d.cbr = mul8(KCBR, r8);
      prod_d.cbg = mul8(KCBG, g8);
      prod_d.cbb = mul8(K128, b8);
      prod_d.crr = mul8(K128, r8);
      prod_d.crg = mul8(KCRG, g8);
      prod_d.crb = mul8(KCRB, b8);
    end

    // Chroma coefficient pairs sum to 128, so the offset sums never wrap.
    if (v1_q) begin
      ys_d  = prod_q.yr + prod_q.yg + prod_q.yb;
      cbs_d = OFS + prod_q.cbb - prod_q.cbr - prod_q.cbg;
      crs_d = OFS + prod_q.crr - prod_q.crg - prod_q.crb;
    end

    if (v2_q) out_d = pack_out(ys_q[15:8], cbs_q[15:8], crs_q[15:8]);
  end

  // NOTE: datapath registers are reset too, so the output word is 0 out of reset.
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      v1_q   <= 1'b0;
      v2_q   <= 1'b0;
      en_q   <= 1'b0;
      prod_q <= '0;
      ys_q   <= '0;
      cbs_q  <= '0;
      crs_q  <= '0;
      out_q  <= '0;
    end else begin
      // NOTE: non-blocking so every stage samples the previous stage's old value.
      v1_q   <= v1_d;
      v2_q   <= v2_d;
      en_q   <= en_d;
      prod_q <= prod_d;
      ys_q   <= ys_d;
      cbs_q  <= cbs_d;
      crs_q  <= crs_d;
      out_q  <= out_d;
    end
  end

  assign sdram_wr_data = out_q;
  assign sdram_wr_en   = en_q;

endmodule

// File: tb/tb_dip_rgb565_ycrcb.sv
// Self-checking bench: four converters (OUT_SEL 0..3) share one input stream and
// are checked against an arithmetic BT.601 model plus a table of known pixels.
module tb_dip_rgb565_ycrcb;

  logic pclk = 1'b0;
  logic rst_n;
  logic [15:0] wr_data [4];
  logic        wr_en   [4];

  dip_rgb565_ycrcb_if bus ();

  always #5 pclk = ~pclk;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    dip_rgb565_ycrcb #(.OUT_SEL(g)) u_dut (
      .pclk          (pclk),
      .rst_n         (rst_n),
      .dip_en        (bus.dip_en),
      .dip_data      (bus.dip_data),
      .sdram_wr_data (wr_data[g]),
      .sdram_wr_en   (wr_en[g])
    );
  end

  int n_checks = 0;
  int n_errors = 0;

  logic        hist_en [3];
  logic [15:0] hist_d  [3];
  logic [15:0] last_exp [4];

  typedef struct {
    logic [15:0] din;
    logic [15:0] exp_gray;
    logic [15:0] exp_cb;
    logic [15:0] exp_cr;
  } vec_t;

  vec_t vecs [5];

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // BT.601 full range from integer arithmetic on the 8-bit expanded components.
  function automatic logic [15:0] ref_pix(input logic [15:0] p, input int sel);
    int r5, g6, b5, r, g, b, y, cb, cr, w;
    r5 = int'(p[15:11]); g6 = int'(p[10:5]); b5 = int'(p[4:0]);
    r  = r5 * 8 + r5 / 4;
    g  = g6 * 4 + g6 / 16;
    b  = b5 * 8 + b5 / 4;
    y  = (77 * r + 150 * g + 29 * b) / 256;
    cb = (32768 + 128 * b - 43 * r - 85 * g) / 256;
    cr = (32768 + 128 * r - 107 * g - 21 * b) / 256;
    case (sel)
      1:       w = y * 256 + cb;
      2:       w = y * 256 + cr;
      default: w = (y / 8) * 2048 + (y / 4) * 32 + (y / 8);
    endcase
    return 16'(w);
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 3; i++) begin hist_en[i] = 1'b0; hist_d[i] = '0; end
    for (int s = 0; s < 4; s++) last_exp[s] = '0;
  endtask

  task automatic check_all_zero(input string tag);
    for (int s = 0; s < 4; s++) begin
      check($sformatf("%s_en%0d", tag, s), 16'(wr_en[s]), 16'h0);
      check($sformatf("%s_data%0d", tag, s), wr_data[s], 16'h0);
    end
  endtask

  // One clock: apply inputs, clock them in, compare against the delayed model.
  task automatic tick(input logic en, input logic [15:0] d);
    bus.dip_en   = en;
    bus.dip_data = d;
    hist_en[2] = hist_en[1]; hist_d[2] = hist_d[1];
    hist_en[1] = hist_en[0]; hist_d[1] = hist_d[0];
    hist_en[0] = en;         hist_d[0] = d;
    @(posedge pclk); #1;
    if (hist_en[2]) for (int s = 0; s < 4; s++) last_exp[s] = ref_pix(hist_d[2], s);
    for (int s = 0; s < 4; s++) begin
      check($sformatf("en%0d", s), 16'(wr_en[s]), 16'(hist_en[2]));
      check($sformatf("data%0d", s), wr_data[s], last_exp[s]);
    end
  endtask

  initial begin
    logic [15:0] cnt;

    vecs[0] = '{16'hFFFF, 16'hFFFF, 16'hFF80, 16'hFF80};
    vecs[1] = '{16'hF800, 16'h4A69, 16'h4C55, 16'h4CFF};
    vecs[2] = '{16'h0000, 16'h0000, 16'h0080, 16'h0080};
    vecs[3] = '{16'h07E0, 16'h94B2, 16'h952B, 16'h9515};
    vecs[4] = '{16'h001F, 16'h18E3, 16'h1CFF, 16'h1C6B};

    rst_n        = 1'b0;
    bus.dip_en   = 1'b0;
    bus.dip_data = 16'h0;
    model_clear();
    for (int i = 0; i < 4; i++) begin
      #49;
      check_all_zero("rst");
    end
    #4 rst_n = 1'b1;
    for (int i = 0; i < 3; i++) tick(1'b0, 16'h0);

    // Known pixels: single pulse, result exactly on the third edge, then idle hold.
    for (int v = 0; v < 5; v++) begin
      tick(1'b1, vecs[v].din);
      tick(1'b0, 16'h0);
      tick(1'b0, 16'h0);
      check("tbl_en",   16'(wr_en[0]), 16'h1);
      check("tbl_gray", wr_data[0], vecs[v].exp_gray);
      check("tbl_cb",   wr_data[1], vecs[v].exp_cb);
      check("tbl_cr",   wr_data[2], vecs[v].exp_cr);
      check("tbl_sel3", wr_data[3], vecs[v].exp_gray);
      tick(1'b0, 16'h0);
      tick(1'b0, 16'h0);
    end

    // Alternating valid with an incrementing pixel on each valid beat.
    cnt = 16'h1234;
    for (int i = 0; i < 40; i++) begin
      tick(i[0] == 1'b0, cnt);
      if (i[0] == 1'b0) cnt = cnt + 16'h0101;
    end

    // Randomised valid pattern and pixels, including back-to-back bursts.
    for (int i = 0; i < 400; i++) tick(($urandom_range(0, 3) != 0), 16'($urandom));

    // Continuous stream with an asynchronous reset pulse in the middle.
    for (int i = 0; i < 10; i++) tick(1'b1, 16'($urandom));
    #2 rst_n = 1'b0;
    #1 check_all_zero("midrst");
    model_clear();
    bus.dip_en = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(posedge pclk); #1;
      check_all_zero("inrst");
    end
    #2 rst_n = 1'b1;
    tick(1'b0, 16'h0);
    tick(1'b0, 16'h0);
    tick(1'b0, 16'h0);
    for (int i = 0; i < 20; i++) tick(1'b1, 16'($urandom));
    for (int i = 0; i < 4; i++) tick(1'b0, 16'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
